native2axil_bridge: RTL and testbench

//  Registered native-to-AXI4-lite master bridge; replaces the combinational adapter.
//  One outstanding native request. Captures request, drives AW/W or AR, collects B/R,

---
 rtl/native2axil_bridge_if.sv | 67 ++++++
 rtl/native2axil_bridge.sv | 160 ++++++++++++++++
 tb/tb_native2axil_bridge.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/native2axil_bridge_if.sv
// Native request/response port plus AXI4-lite master channels of the bridge.
// master = bridge side, slave = CPU/DMA plus interconnect side.
interface native2axil_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  native_valid;
  logic                  native_instr;
  logic [ADDR_WIDTH-1:0] native_addr;
  logic [DATA_WIDTH-1:0] native_wdata;
  logic [STRB_WIDTH-1:0] native_wstrb;
  logic                  native_ready;
  logic [DATA_WIDTH-1:0] native_rdata;
  logic                  native_err;

  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [2:0]            m_axi_awprot;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [STRB_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [2:0]            m_axi_arprot;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;

  modport master (
    input  native_valid, native_instr, native_addr, native_wdata, native_wstrb,
    output native_ready, native_rdata, native_err,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
    input  m_axi_awready,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    input  m_axi_wready,
    input  m_axi_bvalid, m_axi_bresp,
    output m_axi_bready,
    output m_axi_arvalid, m_axi_araddr, m_axi_arprot,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    output m_axi_rready
  );

  modport slave (
    output native_valid, native_instr, native_addr, native_wdata, native_wstrb,
    input  native_ready, native_rdata, native_err,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
    output m_axi_awready,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    output m_axi_wready,
    output m_axi_bvalid, m_axi_bresp,
    input  m_axi_bready,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arprot,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    input  m_axi_rready
  );
endinterface

// File: rtl/native2axil_bridge.sv
// Registered native-to-AXI4-lite bridge, one outstanding request, >=4 cycles/request.
// Define NATIVE2AXIL_TIMEOUT_EN to abort AXI transfers stuck for 2**TIMEOUT_W-1 cycles.
module native2axil_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT_W  = 8
) (
  input logic                 clk,
  input logic                 rst,
  native2axil_bridge_if.master bus
);
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_RESP, DONE} state_t;

  state_t                state_q, state_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  instr_q, instr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  timeout;

`ifdef NATIVE2AXIL_TIMEOUT_EN
  // Fires in the last allowed busy cycle, so the request spends 2**TIMEOUT_W-1 cycles on AXI.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 busy;

  assign busy = (state_q == WR) || (state_q == WR_RESP) ||
                (state_q == RD) || (state_q == RD_RESP);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == IDLE) tmo_cnt_d = '0;
    else if (busy)       tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end

  assign timeout = busy && (tmo_cnt_q == TMO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      instr_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      instr_q   <= instr_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    instr_d   = instr_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (bus.native_valid) begin
          addr_d    = bus.native_addr;
          wdata_d   = bus.native_wdata;
          wstrb_d   = bus.native_wstrb;
          instr_d   = bus.native_instr;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (|bus.native_wstrb) ? WR : RD;
        end
      end
      WR: begin
        aw_done_d = aw_done_q | bus.m_axi_awready;
        w_done_d  = w_done_q | bus.m_axi_wready;
        // No B response can be pending yet, so a timeout here always aborts.
        if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bus.m_axi_bvalid) begin
          state_d = DONE;
          err_d   = bus.m_axi_bresp[1];
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      RD: begin
        if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (bus.m_axi_arready) begin
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (bus.m_axi_rvalid) begin
          state_d = DONE;
          rdata_d = bus.m_axi_rdata;
          err_d   = bus.m_axi_rresp[1];
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.m_axi_awvalid = (state_q == WR) && !aw_done_q;
    bus.m_axi_wvalid  = (state_q == WR) && !w_done_q;
    bus.m_axi_bready  = (state_q == WR_RESP);
    bus.m_axi_arvalid = (state_q == RD);
    bus.m_axi_rready  = (state_q == RD_RESP);
    bus.native_ready  = (state_q == DONE);
  end

  assign bus.m_axi_awaddr = addr_q;
  assign bus.m_axi_awprot = 3'b000;
  assign bus.m_axi_wdata  = wdata_q;
  assign bus.m_axi_wstrb  = wstrb_q;
  assign bus.m_axi_araddr = addr_q;
  assign bus.m_axi_arprot = instr_q ? 3'b100 : 3'b000;
  assign bus.native_rdata = rdata_q;
  assign bus.native_err   = err_q;
endmodule

// File: tb/tb_native2axil_bridge.sv
// Bench for native2axil_bridge: directed cases then random transactions against
// cycle-timing and result expectations derived from the bridge's protocol rules.
module tb_native2axil_bridge;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  native2axil_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  native2axil_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_rdata = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {awvalid, wvalid, bready, arvalid, rready, native_ready}
  function automatic logic [5:0] ctl_vec();
    return {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
            bus.m_axi_arvalid, bus.m_axi_rready, bus.native_ready};
  endfunction

  task automatic slave_idle();
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bvalid  = 1'b0;
    bus.m_axi_bresp   = 2'b00;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'b00;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_ctl"}, ctl_vec(), 6'b0);
    check_val({tag, "_rdata"}, bus.native_rdata, '0);
    check_val({tag, "_err"}, bus.native_err, 1'b0);
    check_val({tag, "_addr"}, {bus.m_axi_awaddr, bus.m_axi_araddr}, 64'd0);
    check_val({tag, "_wdata"}, {bus.m_axi_wstrb, bus.m_axi_wdata}, '0);
    check_val({tag, "_prot"}, {bus.m_axi_awprot, bus.m_axi_arprot}, 6'd0);
  endtask

  // Assert rst for one cycle from the current cycle; outputs checked the cycle after.
  task automatic rst_pulse(input string tag);
    rst = 1'b1;
    bus.native_valid = 1'b0;
    slave_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    ref_rdata = '0;
    @(negedge clk);
    check_reset_state(tag);
    @(posedge clk); #1;
  endtask

  // One native request. Slave raises aw/w/ar ready d_a/d_w cycles after valid first
  // appears, and the response d_r cycles after the address/data handshakes complete.
  task automatic do_txn(input string tag, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [SW-1:0] st, input bit instr,
                        input int d_a, input int d_w, input int d_r,
                        input logic [1:0] resp, input logic [DW-1:0] rd);
    int a_hs, w_hs, m, e, last_hs;
    bit a_seen, w_seen, r_seen;
    logic [5:0] exp_ctl;
    a_hs = 1 + d_a;
    w_hs = wr ? 1 + d_w : 0;
    m = (a_hs > w_hs) ? a_hs : w_hs;
    e = m + 2 + d_r;
    a_seen = 1'b0; w_seen = 1'b0; r_seen = 1'b0; last_hs = 0;
    for (int cyc = 0; cyc <= e; cyc++) begin
      bus.native_valid = 1'b1;
      if (cyc == 0) begin
        bus.native_addr  = addr;
        bus.native_wdata = wd;
        bus.native_wstrb = wr ? st : '0;
        bus.native_instr = instr;
      end else begin
        bus.native_addr  = $urandom;
        bus.native_wdata = $urandom;
        bus.native_wstrb = SW'($urandom);
        bus.native_instr = 1'($urandom);
      end
      bus.m_axi_awready = wr && (cyc >= a_hs);
      bus.m_axi_wready  = wr && (cyc >= w_hs);
      bus.m_axi_arready = !wr && (cyc >= a_hs);
      bus.m_axi_bvalid  = wr && a_seen && w_seen && !r_seen && (cyc >= last_hs + 1 + d_r);
      bus.m_axi_bresp   = bus.m_axi_bvalid ? resp : 2'($urandom);
      bus.m_axi_rvalid  = !wr && a_seen && !r_seen && (cyc >= last_hs + 1 + d_r);
      bus.m_axi_rresp   = bus.m_axi_rvalid ? resp : 2'($urandom);
      bus.m_axi_rdata   = bus.m_axi_rvalid ? rd : DW'($urandom);
      @(negedge clk);
      if (wr)
        exp_ctl = {cyc >= 1 && cyc <= a_hs, cyc >= 1 && cyc <= w_hs,
                   cyc >= m + 1 && cyc <= m + 1 + d_r, 2'b00, cyc == e};
      else
        exp_ctl = {3'b000, cyc >= 1 && cyc <= a_hs,
                   cyc >= a_hs + 1 && cyc <= a_hs + 1 + d_r, cyc == e};
      check_val($sformatf("%s_ctl_c%0d", tag, cyc), ctl_vec(), exp_ctl);
      if (exp_ctl[5]) check_val($sformatf("%s_aw_c%0d", tag, cyc),
                                {bus.m_axi_awprot, bus.m_axi_awaddr}, {3'b000, addr});
      if (exp_ctl[4]) check_val($sformatf("%s_w_c%0d", tag, cyc),
                                {bus.m_axi_wstrb, bus.m_axi_wdata}, {st, wd});
      if (exp_ctl[2]) check_val($sformatf("%s_ar_c%0d", tag, cyc),
                                {bus.m_axi_arprot, bus.m_axi_araddr}, {instr, 2'b00, addr});
      if (cyc >= 1 && cyc < e) check_val($sformatf("%s_err_busy_c%0d", tag, cyc), bus.native_err, 1'b0);
      if (cyc == e) begin
        if (!wr) ref_rdata = rd;
        check_val({tag, "_err"}, bus.native_err, resp[1]);
      end
      check_val($sformatf("%s_rdata_c%0d", tag, cyc), bus.native_rdata, ref_rdata);
      if ((bus.m_axi_awvalid && bus.m_axi_awready) || (bus.m_axi_arvalid && bus.m_axi_arready)) begin
        a_seen = 1'b1; last_hs = (cyc > last_hs) ? cyc : last_hs;
      end
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        w_seen = 1'b1; last_hs = (cyc > last_hs) ? cyc : last_hs;
      end
      if ((bus.m_axi_bvalid && bus.m_axi_bready) || (bus.m_axi_rvalid && bus.m_axi_rready))
        r_seen = 1'b1;
      @(posedge clk); #1;
    end
    bus.native_valid = 1'b0;
    slave_idle();
  endtask

  initial begin
    rst = 1'b1;
    bus.native_valid = 1'b0;
    bus.native_instr = 1'b0;
    bus.native_addr  = '0;
    bus.native_wdata = '0;
    bus.native_wstrb = '0;
    slave_idle();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_txn("wr_basic", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, 0, 0, 2'b00, '0);
    do_txn("wr_wlate", 1'b1, 32'h44, 32'hCAFEF00D, 4'h3, 1'b0, 0, 3, 0, 2'b00, '0);
    do_txn("wr_awlate", 1'b1, 32'h48, 32'h01020304, 4'h8, 1'b0, 2, 0, 1, 2'b00, '0);
    do_txn("rd_instr", 1'b0, 32'h20, '0, '0, 1'b1, 0, 0, 0, 2'b00, 32'h12345678);
    do_txn("wr_hold", 1'b1, 32'h24, 32'h55AA55AA, 4'hF, 1'b0, 1, 1, 2, 2'b00, '0);
    do_txn("rd_slverr", 1'b0, 32'h30, '0, '0, 1'b0, 1, 0, 1, 2'b10, 32'hBADC0DE0);
    do_txn("wr_after_err", 1'b1, 32'h34, 32'h11111111, 4'h1, 1'b0, 0, 0, 0, 2'b00, '0);
    do_txn("wr_decerr", 1'b1, 32'h38, 32'h22222222, 4'hC, 1'b0, 0, 0, 0, 2'b11, '0);

    // Write whose AW channel is never accepted.
    bus.native_valid = 1'b1;
    bus.native_addr  = 32'h80;
    bus.native_wdata = 32'h0BAD0BAD;
    bus.native_wstrb = 4'hF;
    bus.native_instr = 1'b0;
    bus.m_axi_wready = 1'b1;
`ifdef NATIVE2AXIL_TIMEOUT_EN
    for (int cyc = 0; cyc <= 17; cyc++) begin
      @(negedge clk);
      check_val($sformatf("tmo_c%0d", cyc), {bus.m_axi_awvalid, bus.native_ready},
                {cyc >= 1 && cyc <= 15, cyc == 16});
      if (cyc == 16) check_val("tmo_err", bus.native_err, 1'b1);
      @(posedge clk); #1;
      if (cyc == 16) bus.native_valid = 1'b0;
    end
    slave_idle();
`else
    begin
      int bad = 0;
      for (int cyc = 0; cyc <= 100; cyc++) begin
        @(negedge clk);
        if (cyc >= 1 && {bus.m_axi_awvalid, bus.native_ready} !== 2'b10) bad++;
        @(posedge clk); #1;
      end
      check_val("hang_cycles_bad", bad, 0);
    end
    rst_pulse("hang_rst");
`endif

    // Reset pulse while waiting in RD_RESP.
    bus.native_valid = 1'b1;
    bus.native_addr  = 32'h60;
    bus.native_wstrb = '0;
    bus.native_instr = 1'b1;
    bus.m_axi_arready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rdresp_rready", ctl_vec(), 6'b000010);
    @(posedge clk); #1;
    rst_pulse("rdresp_rst");
    do_txn("rd_after_rst", 1'b0, 32'h64, '0, '0, 1'b0, 0, 0, 0, 2'b00, 32'hA5A5A5A5);

    for (int n = 0; n < 40; n++) begin
      bit wr;
      logic [1:0] resp;
      wr = 1'($urandom);
      resp = 2'($urandom);
      do_txn($sformatf("rnd%0d", n), wr, {$urandom_range(0, 16'hFFFF), 2'b00},
             DW'($urandom), SW'($urandom_range(1, 15)), 1'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             resp, DW'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
